mopshub_bus_power_seq: RTL



---
 rtl/mopshub_pkg.sv | 15 +
 rtl/mopshub_cycle_timer.sv | 29 ++
 rtl/mopshub_bus_power_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mopshub_pkg.sv
// Shared MOPSHUB types and constants for the bus power-up sequencer.
package mopshub_pkg;

    localparam int unsigned BUS_IDX_W = 5;
    localparam int unsigned N_BUS_MAX = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        TRIM_WAIT = 3'd2,
        NEXT      = 3'd3,
        DONE      = 3'd4
    } pwr_seq_state_t;

endpackage

// File: rtl/mopshub_cycle_timer.sv
// Clearable up-counter with a terminal-count compare against a run-time limit.
module mopshub_cycle_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk_40_m,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_tc_c
);

    logic [WIDTH-1:0] r_count;

    // Count up while enabled; clear has priority over increment.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Terminal count reached for the currently selected limit.
    assign o_tc_c = (r_count == i_term);

endmodule

// File: rtl/mopshub_bus_power_seq.sv
// Walks bus indices 0..n_buses: power enable, settle, optional oscillator trim.
module mopshub_bus_power_seq
    import mopshub_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 400,
    parameter int unsigned TRIM_TIMEOUT  = 4000
) (
    input  logic                 clk_40_m,
    input  logic                 rst,
    input  logic                 start_power_init,
    input  logic [BUS_IDX_W-1:0] n_buses,
    input  logic                 osc_auto_trim,
    input  logic                 trim_done,
    output logic                 power_bus_en,
    output logic [BUS_IDX_W-1:0] power_bus_cnt,
    output logic [N_BUS_MAX-1:0] power_on,
    output logic                 start_trim,
    output logic                 end_trim_bus,
    output logic                 end_power_init,
    output logic [N_BUS_MAX-1:0] trim_fail_mask,
    output logic                 busy
);

    localparam int unsigned TIMER_MAX = (SETTLE_CYCLES > TRIM_TIMEOUT) ? SETTLE_CYCLES : TRIM_TIMEOUT;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] SETTLE_TERM = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TRIM_TERM   = TIMER_W'(TRIM_TIMEOUT - 1);

    pwr_seq_state_t       r_state;
    pwr_seq_state_t       w_state_nxt;
    logic [BUS_IDX_W-1:0] r_n_buses;
    logic                 r_trim_en;

    logic                 w_tmr_clr;
    logic                 w_tmr_inc;
    logic [TIMER_W-1:0]   w_tmr_term;
    logic                 w_tmr_tc;

    logic [BUS_IDX_W-1:0] w_n_buses_nxt;
    logic                 w_trim_en_nxt;
    logic                 w_en_nxt;
    logic [BUS_IDX_W-1:0] w_cnt_nxt;
    logic [BUS_IDX_W-1:0] w_cnt_inc;
    logic [N_BUS_MAX-1:0] w_on_nxt;
    logic                 w_start_trim_nxt;
    logic                 w_end_trim_nxt;
    logic                 w_end_init_nxt;
    logic [N_BUS_MAX-1:0] w_fail_nxt;
    logic                 w_busy_nxt;

    // The settle and trim windows share one timer; the limit follows the state.
    assign w_tmr_term = (r_state == TRIM_WAIT) ? TRIM_TERM : SETTLE_TERM;
    assign w_cnt_inc  = power_bus_cnt + BUS_IDX_W'(1);

    mopshub_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_inc    (w_tmr_inc),
        .i_term   (w_tmr_term),
        .o_tc_c   (w_tmr_tc)
    );

    // State register plus registered status outputs.
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_n_buses      <= '0;
            r_trim_en      <= 1'b0;
            power_bus_en   <= 1'b0;
            power_bus_cnt  <= '0;
            power_on       <= '0;
            start_trim     <= 1'b0;
            end_trim_bus   <= 1'b0;
            end_power_init <= 1'b0;
            trim_fail_mask <= '0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_n_buses      <= w_n_buses_nxt;
            r_trim_en      <= w_trim_en_nxt;
            power_bus_en   <= w_en_nxt;
            power_bus_cnt  <= w_cnt_nxt;
            power_on       <= w_on_nxt;
            start_trim     <= w_start_trim_nxt;
            end_trim_bus   <= w_end_trim_nxt;
            end_power_init <= w_end_init_nxt;
            trim_fail_mask <= w_fail_nxt;
            busy           <= w_busy_nxt;
        end
    end

    // Next-state and next-output decode; pulses default low, status holds.
    always_comb begin
        w_state_nxt      = r_state;
        w_n_buses_nxt    = r_n_buses;
        w_trim_en_nxt    = r_trim_en;
        w_en_nxt         = power_bus_en;
        w_cnt_nxt        = power_bus_cnt;
        w_on_nxt         = power_on;
        w_fail_nxt       = trim_fail_mask;
        w_busy_nxt       = busy;
        w_start_trim_nxt = 1'b0;
        w_end_trim_nxt   = 1'b0;
        w_end_init_nxt   = 1'b0;
        w_tmr_clr        = 1'b1;
        w_tmr_inc        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_power_init) begin
                    w_n_buses_nxt = n_buses;
                    w_trim_en_nxt = osc_auto_trim;
                    w_cnt_nxt     = '0;
                    w_on_nxt      = N_BUS_MAX'(1);
                    w_fail_nxt    = '0;
                    w_en_nxt      = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = SETTLE;
                end
            end
            SETTLE: begin
                if (w_tmr_tc) begin
                    if (r_trim_en) begin
                        w_start_trim_nxt = 1'b1;
                        w_state_nxt      = TRIM_WAIT;
                    end else begin
                        w_en_nxt       = 1'b0;
                        w_end_trim_nxt = 1'b1;
                        w_state_nxt    = NEXT;
                    end
                end else begin
                    w_tmr_clr = 1'b0;
                    w_tmr_inc = 1'b1;
                end
            end
            TRIM_WAIT: begin
                // An ack in the timeout cycle still counts as success.
                if (trim_done) begin
                    w_en_nxt       = 1'b0;
                    w_end_trim_nxt = 1'b1;
                    w_state_nxt    = NEXT;
                end else if (w_tmr_tc) begin
                    w_fail_nxt     = trim_fail_mask | (N_BUS_MAX'(1) << power_bus_cnt);
                    w_en_nxt       = 1'b0;
                    w_end_trim_nxt = 1'b1;
                    w_state_nxt    = NEXT;
                end else begin
                    w_tmr_clr = 1'b0;
                    w_tmr_inc = 1'b1;
                end
            end
            NEXT: begin
                if (power_bus_cnt == r_n_buses) begin
                    w_end_init_nxt = 1'b1;
                    w_state_nxt    = DONE;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_on_nxt    = power_on | (N_BUS_MAX'(1) << w_cnt_inc);
                    w_en_nxt    = 1'b1;
                    w_state_nxt = SETTLE;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
